gate_test_sequencer: RTL and testbench
======================================

Name: gate_test_sequencer

Overview:
- Upstream/downstream companion to the two-input basic-gates block: drives its `a`/`b` inputs through all four input combinations.
- Waits a programmable settle time, samples the six gate outputs and compares them against an internal truth table.
- Reports pass/fail, a per-gate error mask and a failing-vector count.
- Serves as the on-chip self-test wrapper around the gates block.

Parameters:
- HOLD_CYCLES, 2, settle cycles per vector before sampling; legal range ≥1.
- CNT_W, 4, width of the internal hold counter; must satisfy 2^CNT_W > HOLD_CYCLES.

Ports:
- clk  input  1  single system clock; all logic on rising edge.
- rst  input  1  synchronous, active-high reset.
- start  input  1  level-sampled request to run one self-test pass.
- a  output  1  registered drive to gates block input a.
- b  output  1  registered drive to gates block input b.
- gate_out  input  6  gate results, packed {xnorc,xorc,norc,nandc,orc,andc}; bit0=andc … bit5=xnorc.
- busy  output  1  high while a pass is running.
- done  output  1  high from pass completion until the next accepted start or reset.
- pass  output  1  done && no mismatches.
- err_mask  output  6  sticky OR of per-gate mismatches over the pass.
- err_count  output  3  number of vectors (0..4) with any mismatch.

Behaviour:
- Reset (rst=1 at clk edge), regardless of state, clears everything next cycle:
  - state=IDLE; a=b=0; busy=done=pass=0; err_mask=0; err_count=0; vec=0; hold_cnt=0.
- FSM states: IDLE, DRIVE, SAMPLE, DONE.
- IDLE:
  - a=b=0.
  - start=1 → DRIVE; vec=0; hold_cnt=0; err_mask/err_count cleared; busy=1.
- DRIVE:
  - {a,b}=vec (a=vec[1], b=vec[0]), registered.
  - hold_cnt increments each cycle.
  - When hold_cnt==HOLD_CYCLES-1 → SAMPLE.
- SAMPLE (exactly one cycle):
  - Compute mismatch = gate_out ^ expected(vec), where expected = {~(a^b), a^b, ~(a|b), ~(a&b), a|b, a&b}.
  - err_mask |= mismatch; err_count += (|mismatch).
  - If vec==3 → DONE. Otherwise vec++, hold_cnt=0, → DRIVE.
- DONE:
  - busy=0; done=1; a=b=0; pass = (err_count==0).
  - start=1 → restart exactly as from IDLE (results cleared, done drops next cycle).
- Timing (start sampled at edge 0):
  - busy rises at edge 1.
  - Each vector occupies HOLD_CYCLES+1 cycles; a/b change only on DRIVE entry.
  - done rises at edge 1+4*(HOLD_CYCLES+1), e.g. edge 13 for HOLD_CYCLES=2.
- start while busy (DRIVE/SAMPLE) is ignored; no queuing.
- rst and start high in the same cycle: rst wins.
- err_count cannot overflow (max 4 fits 3 bits); the vec counter wraps only via the DONE exit, never 3→0 in SAMPLE.
- gate_out is sampled only in SAMPLE; it is don't-care at all other times, including X values.

Optional Feature:
- Macro GATE_TEST_FIRST_FAIL_EN.
- When defined:
  - Adds output first_fail_vec (2 bits) and first_fail_vld (1 bit).
  - On the first SAMPLE with a nonzero mismatch, latch vec and set first_fail_vld=1.
  - Both are cleared by reset and by an accepted start.
- When undefined: neither port exists; behaviour is otherwise identical.

Decomposition:
- Shared package gate_test_pkg:
  - State enum (IDLE, DRIVE, SAMPLE, DONE).
  - Bit-index constants AND_IDX=0, OR_IDX=1, NAND_IDX=2, NOR_IDX=3, XOR_IDX=4, XNOR_IDX=5.
  - NUM_VEC=4.
- One natural sub-module, gate_expect_lut: purely combinational, 2-bit vec → 6-bit expected vector, reused by the testbench scoreboard.

Test Plan:
- Ideal gates connected, HOLD_CYCLES=2, start pulse at edge 0 → {a,b} sequence 00,01,10,11 at edges 1,4,7,10; done=1 and pass=1 at edge 13; err_mask=6'b000000; err_count=0.
- andc forced 0 → only vector 11 fails: err_mask=6'b000001, err_count=1, pass=0; with GATE_TEST_FIRST_FAIL_EN, first_fail_vec=2'b11 and first_fail_vld=1.
- xorc inverted → all vectors fail: err_mask=6'b010000, err_count=4, pass=0.
- rst=1 asserted during DRIVE of vector 10 → next cycle busy=0, a=b=0, err_mask=0, done=0; a later start runs a full clean pass.
- start held high through the whole pass → no restart while busy; restart taken in DONE (done drops, busy rises the next cycle, err counters cleared).
- rst and start both high in IDLE → stays IDLE, busy remains 0.

Source files
------------

// File: rtl/gate_test_pkg.sv
// Shared types and constants for the gate self-test sequencer and its expected-value LUT.
package gate_test_pkg;

  typedef enum logic [1:0] {
    IDLE,
    DRIVE,
    SAMPLE,
    DONE
  } state_t;

  localparam int unsigned AND_IDX   = 0;
  localparam int unsigned OR_IDX    = 1;
  localparam int unsigned NAND_IDX  = 2;
  localparam int unsigned NOR_IDX   = 3;
  localparam int unsigned XOR_IDX   = 4;
  localparam int unsigned XNOR_IDX  = 5;
  localparam int unsigned NUM_GATES = 6;
  localparam int unsigned NUM_VEC   = 4;

endpackage

// File: rtl/gate_expect_lut.sv
// Combinational truth table: 2-bit input vector {a,b} -> expected six gate outputs.
module gate_expect_lut
  import gate_test_pkg::*;
(
  input  logic [1:0]           vec_i,
  output logic [NUM_GATES-1:0] expected_o
);

  logic va;
  logic vb;

  assign va = vec_i[1];
  assign vb = vec_i[0];

  always_comb begin
    expected_o           = '0;
    expected_o[AND_IDX]  = va & vb;
    expected_o[OR_IDX]   = va | vb;
    expected_o[NAND_IDX] = ~(va & vb);
    expected_o[NOR_IDX]  = ~(va | vb);
    expected_o[XOR_IDX]  = va ^ vb;
    expected_o[XNOR_IDX] = ~(va ^ vb);
  end

endmodule

// File: rtl/gate_test_sequencer.sv
// Self-test sequencer for the two-input basic-gates block: drives all four {a,b} vectors,
// checks the six gate outputs after a settle time. Optional macro: GATE_TEST_FIRST_FAIL_EN.
module gate_test_sequencer
  import gate_test_pkg::*;
#(
  parameter int unsigned HOLD_CYCLES = 2,
  parameter int unsigned CNT_W       = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  output logic                 a,
  output logic                 b,
  input  logic [NUM_GATES-1:0] gate_out,
  output logic                 busy,
  output logic                 done,
  output logic                 pass,
  output logic [NUM_GATES-1:0] err_mask,
  output logic [2:0]           err_count
`ifdef GATE_TEST_FIRST_FAIL_EN
  ,
  output logic [1:0]           first_fail_vec,
  output logic                 first_fail_vld
`endif
);

  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_CYCLES - 1);
  localparam logic [1:0]       LAST_VEC  = 2'(NUM_VEC - 1);

  state_t               state_q;
  logic [1:0]           vec_q;
  logic [CNT_W-1:0]     hold_q;
  logic                 a_q;
  logic                 b_q;
  logic                 busy_q;
  logic                 done_q;
  logic                 pass_q;
  logic [NUM_GATES-1:0] err_mask_q;
  logic [2:0]           err_cnt_q;

  logic [NUM_GATES-1:0] expected;
  logic [NUM_GATES-1:0] mismatch;
  logic                 any_mis;
  logic [2:0]           err_cnt_d;
  logic [1:0]           vec_d;

  gate_expect_lut u_lut (
    .vec_i      (vec_q),
    .expected_o (expected)
  );

  always_comb begin
    mismatch  = gate_out ^ expected;
    any_mis   = |mismatch;
    err_cnt_d = err_cnt_q + {2'b00, any_mis};
    vec_d     = vec_q + 2'd1;
  end

`ifdef GATE_TEST_FIRST_FAIL_EN
  logic [1:0] ff_vec_q;
  logic       ff_vld_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      ff_vec_q <= '0;
      ff_vld_q <= 1'b0;
    end else if ((state_q == IDLE || state_q == DONE) && start) begin
      ff_vec_q <= '0;
      ff_vld_q <= 1'b0;
    end else if (state_q == SAMPLE && any_mis && !ff_vld_q) begin
      ff_vec_q <= vec_q;
      ff_vld_q <= 1'b1;
    end
  end

  assign first_fail_vec = ff_vec_q;
  assign first_fail_vld = ff_vld_q;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      vec_q      <= '0;
      hold_q     <= '0;
      a_q        <= 1'b0;
      b_q        <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      pass_q     <= 1'b0;
      err_mask_q <= '0;
      err_cnt_q  <= '0;
    end else begin
      case (state_q)
        IDLE, DONE: begin
          a_q <= 1'b0;
          b_q <= 1'b0;
          if (start) begin
            state_q    <= DRIVE;
            vec_q      <= '0;
            hold_q     <= '0;
            busy_q     <= 1'b1;
            done_q     <= 1'b0;
            pass_q     <= 1'b0;
            err_mask_q <= '0;
            err_cnt_q  <= '0;
          end
        end
        DRIVE: begin
          a_q    <= vec_q[1];
          b_q    <= vec_q[0];
          hold_q <= hold_q + 1'b1;
          if (hold_q == HOLD_LAST) begin
            state_q <= SAMPLE;
          end
        end
        SAMPLE: begin
          err_mask_q <= err_mask_q | mismatch;
          err_cnt_q  <= err_cnt_d;
          if (vec_q == LAST_VEC) begin
            // pass uses the count including this final vector's result
            state_q <= DONE;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            pass_q  <= (err_cnt_d == 3'd0);
            a_q     <= 1'b0;
            b_q     <= 1'b0;
          end else begin
            state_q <= DRIVE;
            vec_q   <= vec_d;
            hold_q  <= '0;
            a_q     <= vec_d[1];
            b_q     <= vec_d[0];
          end
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign a         = a_q;
  assign b         = b_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign pass      = pass_q;
  assign err_mask  = err_mask_q;
  assign err_count = err_cnt_q;

endmodule

// File: tb/tb_gate_test_sequencer.sv
// Self-checking bench for gate_test_sequencer: modelled gates block with injectable faults,
// directed table, randomized passes and multi-cycle corner sequences.
module tb_gate_test_sequencer;
  import gate_test_pkg::*;

  localparam int unsigned H        = 2;
  localparam int unsigned VLEN     = H + 1;
  localparam int unsigned PASS_LEN = 4 * VLEN;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic       a;
  logic       b;
  logic [5:0] gate_out;
  logic       busy;
  logic       done;
  logic       pass;
  logic [5:0] err_mask;
  logic [2:0] err_count;
`ifdef GATE_TEST_FIRST_FAIL_EN
  logic [1:0] first_fail_vec;
  logic       first_fail_vld;
`endif

  logic [5:0] flt [4];
  logic [1:0] lut_vec;
  logic [5:0] lut_exp;

  int n_chk  = 0;
  int n_pass = 0;

  always #5 clk = ~clk;

  gate_test_sequencer #(.HOLD_CYCLES(H), .CNT_W(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .a         (a),
    .b         (b),
    .gate_out  (gate_out),
    .busy      (busy),
    .done      (done),
    .pass      (pass),
    .err_mask  (err_mask),
`ifdef GATE_TEST_FIRST_FAIL_EN
    .err_count (err_count),
    .first_fail_vec (first_fail_vec),
    .first_fail_vld (first_fail_vld)
`else
    .err_count (err_count)
`endif
  );

  gate_expect_lut u_lut_chk (
    .vec_i      (lut_vec),
    .expected_o (lut_exp)
  );

  // Gate truth values from the number of ones on the inputs
  function automatic logic [5:0] truth(input int unsigned x, input int unsigned y);
    int unsigned s;
    logic [5:0] r;
    s    = x + y;
    r[0] = (s == 2);
    r[1] = (s >= 1);
    r[2] = (s != 2);
    r[3] = (s == 0);
    r[4] = (s == 1);
    r[5] = (s != 1);
    return r;
  endfunction

  // Gates block model: outputs meaningless (X) while the sequencer is not running
  always_comb begin
    gate_out = 'x;
    if (busy) gate_out = truth(int'(a), int'(b)) ^ flt[{a, b}];
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic set_flt(input logic [23:0] flts);
    for (int v = 0; v < 4; v++) flt[v] = flts[v*6 +: 6];
  endtask

  task automatic run_pass(input logic [23:0] flts, input logic [5:0] e_mask,
                          input logic [2:0] e_cnt, input logic e_pass,
                          input logic [1:0] e_ffv, input logic e_ffvld);
    set_flt(flts);
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
    for (int unsigned k = 0; k <= PASS_LEN; k++) begin
      chk("busy", 32'(busy), 32'(k < PASS_LEN));
      chk("done", 32'(done), 32'(k == PASS_LEN));
      chk("ab", 32'({a, b}), (k < PASS_LEN) ? k / VLEN : 32'd0);
      if (k < PASS_LEN) @(negedge clk);
    end
    chk("err_mask", 32'(err_mask), 32'(e_mask));
    chk("err_count", 32'(err_count), 32'(e_cnt));
    chk("pass", 32'(pass), 32'(e_pass));
`ifdef GATE_TEST_FIRST_FAIL_EN
    chk("ff_vld", 32'(first_fail_vld), 32'(e_ffvld));
    chk("ff_vec", 32'(first_fail_vec), 32'(e_ffv));
`else
    if (e_ffvld && e_ffv == 2'd3) begin end
`endif
  endtask

  typedef struct {
    logic [23:0] flts;
    logic [5:0]  e_mask;
    logic [2:0]  e_cnt;
    logic        e_pass;
    logic [1:0]  e_ffv;
    logic        e_ffvld;
  } vec_t;

  vec_t tbl [5];

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // flts packs the per-vector fault masks: vector v occupies bits [6v+5:6v]
    tbl[0] = '{flts: 24'h0, e_mask: 6'b000000, e_cnt: 3'd0, e_pass: 1'b1, e_ffv: 2'd0, e_ffvld: 1'b0};
    tbl[1] = '{flts: {6'b000001, 18'b0}, e_mask: 6'b000001, e_cnt: 3'd1, e_pass: 1'b0, e_ffv: 2'd3, e_ffvld: 1'b1};
    tbl[2] = '{flts: {4{6'b010000}}, e_mask: 6'b010000, e_cnt: 3'd4, e_pass: 1'b0, e_ffv: 2'd0, e_ffvld: 1'b1};
    tbl[3] = '{flts: {6'b000000, 6'b100000, 6'b001000, 6'b000000}, e_mask: 6'b101000, e_cnt: 3'd2,
               e_pass: 1'b0, e_ffv: 2'd1, e_ffvld: 1'b1};
    tbl[4] = '{flts: {6'b000000, 6'b111111, 6'b000000, 6'b111111}, e_mask: 6'b111111, e_cnt: 3'd2,
               e_pass: 1'b0, e_ffv: 2'd0, e_ffvld: 1'b1};

    rst = 1'b1;
    start = 1'b0;
    lut_vec = 2'd0;
    set_flt(24'h0);

    for (int v = 0; v < 4; v++) begin
      lut_vec = 2'(v);
      #1;
      chk("lut", 32'(lut_exp), 32'(truth(int'(v) / 2, int'(v) % 2)));
    end

    repeat (2) @(negedge clk);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_pass", 32'(pass), 32'd0);
    chk("rst_ab", 32'({a, b}), 32'd0);
    chk("rst_mask", 32'(err_mask), 32'd0);
    chk("rst_cnt", 32'(err_count), 32'd0);
    rst = 1'b0;

    for (int i = 0; i < 5; i++)
      run_pass(tbl[i].flts, tbl[i].e_mask, tbl[i].e_cnt, tbl[i].e_pass, tbl[i].e_ffv, tbl[i].e_ffvld);

    for (int it = 0; it < 20; it++) begin
      logic [23:0] flts;
      logic [5:0]  m_mask;
      logic [2:0]  m_cnt;
      logic [1:0]  m_ffv;
      logic        m_vld;
      m_mask = '0;
      m_cnt  = '0;
      m_ffv  = '0;
      m_vld  = 1'b0;
      for (int v = 0; v < 4; v++)
        flts[v*6 +: 6] = ($urandom_range(0, 1) == 1) ? 6'($urandom) : 6'd0;
      for (int v = 0; v < 4; v++) begin
        m_mask = m_mask | flts[v*6 +: 6];
        if (flts[v*6 +: 6] != 6'd0) begin
          m_cnt = m_cnt + 3'd1;
          if (!m_vld) begin
            m_ffv = 2'(v);
            m_vld = 1'b1;
          end
        end
      end
      run_pass(flts, m_mask, m_cnt, (m_cnt == 3'd0), m_ffv, m_vld);
    end

    // start held high through a whole pass: ignored while busy, restart taken in DONE
    set_flt({4{6'b010000}});
    @(negedge clk) start = 1'b1;
    @(negedge clk);
    for (int unsigned k = 0; k <= PASS_LEN; k++) begin
      chk("hold_busy", 32'(busy), 32'(k < PASS_LEN));
      chk("hold_ab", 32'({a, b}), (k < PASS_LEN) ? k / VLEN : 32'd0);
      @(negedge clk);
    end
    chk("restart_done", 32'(done), 32'd0);
    chk("restart_busy", 32'(busy), 32'd1);
    chk("restart_mask", 32'(err_mask), 32'd0);
    chk("restart_cnt", 32'(err_count), 32'd0);
    start = 1'b0;
    begin
      int unsigned t;
      t = 0;
      while (!done && t < 100) begin
        @(negedge clk);
        t++;
      end
      chk("restart_timeout", 32'(done), 32'd1);
    end
    chk("restart_end_cnt", 32'(err_count), 32'd4);

    // reset while driving vector 10
    set_flt({4{6'b010000}});
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
    repeat (2 * VLEN) @(negedge clk);
    chk("mid_ab", 32'({a, b}), 32'b10);
    chk("mid_cnt", 32'(err_count), 32'd2);
    rst = 1'b1;
    @(negedge clk);
    chk("midrst_busy", 32'(busy), 32'd0);
    chk("midrst_ab", 32'({a, b}), 32'd0);
    chk("midrst_mask", 32'(err_mask), 32'd0);
    chk("midrst_done", 32'(done), 32'd0);
    rst = 1'b0;
    run_pass(tbl[0].flts, tbl[0].e_mask, tbl[0].e_cnt, tbl[0].e_pass, tbl[0].e_ffv, tbl[0].e_ffvld);

    // rst and start together: rst wins
    @(negedge clk);
    rst = 1'b1;
    start = 1'b1;
    @(negedge clk);
    chk("rst_start_busy", 32'(busy), 32'd0);
    rst = 1'b0;
    start = 1'b0;
    @(negedge clk);
    chk("rst_start_busy2", 32'(busy), 32'd0);
    chk("rst_start_done", 32'(done), 32'd0);
`ifdef GATE_TEST_FIRST_FAIL_EN
    chk("rst_start_ffvld", 32'(first_fail_vld), 32'd0);
`endif

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
